checksum_stream: RTL and testbench
==================================

Name: checksum_stream

Overview:
- Multi-lane, frame-based successor to the single-word checksum core.
- Accepts p_LANES words per beat over a valid/ready stream with frame delimiting (i_last).
- Ones- or twos-complement arithmetic is selected per frame at runtime.
- Runs in generate mode (outputs the checksum word) or verify mode (the frame carries its checksum and the block flags pass/fail). Sits between packet framers and the link layer on both TX and RX sides.

Parameters:
p_WORD_LEN, 16, checksum word width W
p_LANES, 4, words per input beat (1..8)
p_LEN_W, 16, width of the word counter and of the accumulator guard bits G

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_data  in  p_LANES*p_WORD_LEN  beat data; lane k = bits [k*W +: W], lane 0 = first word
i_keep  in  p_LANES  lane valid mask; cleared lanes contribute 0 and are not counted
i_valid  in  1  beat valid
i_last  in  1  final beat of frame (qualified by i_valid)
i_mode  in  1  0 = ones complement, 1 = twos complement; sampled on first beat of frame
i_check  in  1  0 = generate, 1 = verify; sampled on first beat of frame
o_ready  out  1  beat accepted when i_valid & o_ready
o_checksum  out  p_WORD_LEN  result checksum
o_ok  out  1  verify result (generate mode: 0)
o_err  out  1  word-count overflow in the frame
o_count  out  p_LEN_W  words accepted in the frame, saturating
o_done  out  1  one-cycle pulse: outputs valid

Behaviour:
- Reset: state IDLE. o_ready=1; o_checksum=0, o_ok=0, o_err=0, o_count=0, o_done=0. Accumulator cleared.
- Reset mid-frame aborts the frame. No o_done is produced; all state returns to the reset values.
- Accumulator A is W+G bits wide.
  - Each accepted beat: A <= A + sum of kept lanes, each lane zero-extended.
  - Count <= count + popcount(i_keep), saturating at 2^G-1.
  - The first beat of a frame loads A rather than adding to it; mode and check are latched on that beat.
- States:
  - IDLE: o_ready=1. Accepted beat with i_last=0 -> ACCUM. Accepted beat with i_last=1 -> FOLD1.
  - ACCUM: o_ready=1. Accepted beat with i_last=1 -> FOLD1.
  - FOLD1: o_ready=0. Ones mode: A <= A[W-1:0] + A[W+G-1:W]. Twos mode: A <= A[W-1:0]. -> FOLD2.
  - FOLD2: o_ready=0. Ones mode repeats the fold; two folds always leave the upper bits zero. Twos mode holds. -> DONE.
  - DONE: o_ready=0. o_done=1 for exactly this cycle. -> IDLE.
- Fixed latency: o_done is high in the third cycle after the clock edge that accepted the last beat, independent of mode.
- Result S = A[W-1:0] after folding:
  - Generate, ones mode: o_checksum = ~S.
  - Generate, twos mode: o_checksum = (~S)+1 mod 2^W.
  - Verify, ones mode: o_ok = (S == all ones). o_checksum = ~S, which is 0 when ok.
  - Verify, twos mode: o_ok = (S == 0). o_checksum = (~S)+1.
- Overflow: if the word count would reach 2^G, o_err=1 and o_ok is forced to 0. The checksum value is then undefined.
- o_checksum, o_ok, o_err and o_count are registered at DONE. They hold until the first beat of the next frame is accepted, then clear.
- i_valid=1 with i_keep=0 is a legal beat. It counts 0 words, and may carry i_last, which ends the frame.
- A single-beat frame (i_last on the first beat) is legal.
- i_mode and i_check changes mid-frame are ignored.
- i_valid while o_ready=0 is not accepted. The source must hold its data; no state changes.

Test Plan:
- Ones generate, W=16, one beat {0x0001,0xFFFF}, keep=0011, last: S=0x0001 after end-around carry -> o_checksum=0xFFFE, o_count=2, o_done exactly 3 cycles after acceptance.
- Twos generate, same beat: sum 0x0000 -> o_checksum=0x0000. Then words 0x1234,0x5678 -> o_checksum=0x9754.
- Ones generate 0x1234,0x5678 -> 0x9753. Verify frame 0x1234,0x5678,0x9753 over two beats, keep 1111 then 0000+last -> o_ok=1, o_checksum=0x0000, o_count=3.
- Verify with one bit flipped (0x1235) -> o_ok=0. Twos verify 0x1234,0x5678,0x9754 -> o_ok=1.
- 100 random beats with random i_valid gaps; i_valid held during FOLD/DONE -> matches reference-model checksum in both modes. No beat lost or double-counted; o_ready=0 for the 3 post-last cycles.
- Assert i_reset during ACCUM, then send frame {0xFFFF} -> no o_done from the aborted frame, new o_checksum=0x0000 in ones mode. With p_LEN_W=4, 16 words -> o_err=1, o_ok=0, o_count=15.

Source files
------------

// File: rtl/checksum_stream.sv
// Multi-lane, frame-based ones/twos-complement checksum with generate and verify modes.
// Wide accumulator absorbs a whole frame; two folds reduce it to one word before the result is registered.
module checksum_stream #(
  parameter int p_WORD_LEN = 16,
  parameter int p_LANES    = 4,
  parameter int p_LEN_W    = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [p_LANES*p_WORD_LEN-1:0]   i_data,
  input  logic [p_LANES-1:0]              i_keep,
  input  logic                            i_valid,
  input  logic                            i_last,
  input  logic                            i_mode,
  input  logic                            i_check,
  output logic                            o_ready,
  output logic [p_WORD_LEN-1:0]           o_checksum,
  output logic                            o_ok,
  output logic                            o_err,
  output logic [p_LEN_W-1:0]              o_count,
  output logic                            o_done
);

  localparam int W  = p_WORD_LEN;
  localparam int G  = p_LEN_W;
  localparam int AW = W + G;
  localparam int CW = G + 4;

  typedef enum logic [2:0] {IDLE, ACCUM, FOLD1, FOLD2, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [G-1:0]  count;
  logic          err;
  logic          mode_q;
  logic          check_q;

  logic [AW-1:0] beat_sum;
  logic [3:0]    beat_pop;
  logic          first;
  logic          accept;
  logic [AW-1:0] acc_next;
  logic [CW-1:0] cnt_sum;
  logic          cnt_ovf;
  logic [G-1:0]  cnt_next;
  logic          err_next;
  logic [AW-1:0] fold_val;
  logic [W-1:0]  s_val;

  always_comb begin
    beat_sum = '0;
    beat_pop = '0;
    for (int unsigned k = 0; k < p_LANES; k++) begin
      if (i_keep[k]) begin
        beat_sum = beat_sum + AW'(i_data[k*W +: W]);
        beat_pop = beat_pop + 4'd1;
      end
    end
  end

  assign first    = (state == IDLE);
  assign accept   = i_valid && o_ready;
  assign acc_next = first ? beat_sum : acc + beat_sum;

  // Count is summed one nibble wider so a frame crossing 2^G words is seen before saturation hides it.
  assign cnt_sum  = (first ? '0 : CW'(count)) + CW'(beat_pop);
  assign cnt_ovf  = (cnt_sum > CW'({G{1'b1}}));
  assign cnt_next = cnt_ovf ? '1 : cnt_sum[G-1:0];
  assign err_next = (first ? 1'b0 : err) | cnt_ovf;

  assign fold_val = mode_q ? AW'(acc[W-1:0])
                           : AW'(acc[W-1:0]) + AW'(acc[AW-1:W]);
  assign s_val    = fold_val[W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      acc        <= '0;
      count      <= '0;
      err        <= 1'b0;
      mode_q     <= 1'b0;
      check_q    <= 1'b0;
      o_checksum <= '0;
      o_ok       <= 1'b0;
      o_err      <= 1'b0;
      o_count    <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= acc_next;
            count <= cnt_next;
            err   <= err_next;
            if (first) begin
              mode_q     <= i_mode;
              check_q    <= i_check;
              o_checksum <= '0;
              o_ok       <= 1'b0;
              o_err      <= 1'b0;
              o_count    <= '0;
            end
            if (i_last) begin
              state   <= FOLD1;
              o_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        FOLD1: begin
          acc   <= fold_val;
          state <= FOLD2;
        end
        FOLD2: begin
          // Second fold is taken combinationally so the result is registered on entry to DONE.
          acc        <= fold_val;
          o_checksum <= mode_q ? (~s_val) + W'(1) : ~s_val;
          o_ok       <= check_q && !err && (mode_q ? (s_val == '0) : (s_val == '1));
          o_err      <= err;
          o_count    <= count;
          o_done     <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checksum_stream.sv
// Bench for checksum_stream: frame-level arithmetic model checked every cycle, plus literal expectations.
module tb_checksum_stream;

  localparam int W = 16;
  localparam int G = 16;

  logic        clk;
  logic        i_reset;
  logic [63:0] i_data;
  logic [3:0]  i_keep;
  logic        i_valid, i_last, i_mode, i_check;
  logic        o_ready, o_ok, o_err, o_done;
  logic [15:0] o_checksum;
  logic [15:0] o_count;

  logic [63:0] s_data;
  logic [3:0]  s_keep;
  logic        s_valid, s_last, s_mode, s_check;
  logic        s_ready, s_ok, s_err, s_done;
  logic [15:0] s_cs;
  logic [3:0]  s_cnt;

  checksum_stream #(.p_WORD_LEN(16), .p_LANES(4), .p_LEN_W(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_keep(i_keep),
    .i_valid(i_valid), .i_last(i_last), .i_mode(i_mode), .i_check(i_check),
    .o_ready(o_ready), .o_checksum(o_checksum), .o_ok(o_ok), .o_err(o_err),
    .o_count(o_count), .o_done(o_done)
  );

  checksum_stream #(.p_WORD_LEN(16), .p_LANES(4), .p_LEN_W(4)) dut_small (
    .i_clk(clk), .i_reset(i_reset), .i_data(s_data), .i_keep(s_keep),
    .i_valid(s_valid), .i_last(s_last), .i_mode(s_mode), .i_check(s_check),
    .o_ready(s_ready), .o_checksum(s_cs), .o_ok(s_ok), .o_err(s_err),
    .o_count(s_cnt), .o_done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: collects kept words, computes the result with plain arithmetic at i_last.
  logic [15:0] wq[$];
  int          busy = 0;
  bit          in_frame = 0, f_mode = 0, f_check = 0;
  bit          exp_ready = 1, exp_done = 0, cs_defined = 1;
  logic [15:0] e_cs = '0, p_cs;
  logic [15:0] e_cnt = '0, p_cnt;
  bit          e_ok = 0, e_err = 0, p_ok, p_err;
  bit          cmp_en = 0;

  task automatic frame_result();
    longint unsigned s = 0;
    longint unsigned m = (64'd1 << W) - 1;
    longint unsigned n = longint'(wq.size());
    logic [15:0] sv;
    foreach (wq[i]) s += longint'(wq[i]);
    p_err = (n >= (64'd1 << G));
    p_cnt = p_err ? 16'hFFFF : 16'(n);
    if (f_mode) s = s & m;
    else while ((s >> W) != 0) s = (s & m) + (s >> W);
    sv = 16'(s);
    p_cs = f_mode ? 16'(-sv) : ~sv;
    p_ok = f_check && !p_err && (f_mode ? (sv == 16'h0000) : (sv == 16'hFFFF));
  endtask

  always @(posedge clk) begin
    if (i_reset) begin
      busy = 0; in_frame = 0; wq.delete();
      e_cs = '0; e_ok = 0; e_err = 0; e_cnt = '0; cs_defined = 1;
    end else if (busy != 0) begin
      if (busy == 2) begin
        e_cs = p_cs; e_ok = p_ok; e_err = p_err; e_cnt = p_cnt; cs_defined = !p_err;
      end
      busy--;
    end else if (i_valid) begin
      if (!in_frame) begin
        e_cs = '0; e_ok = 0; e_err = 0; e_cnt = '0;
        f_mode = i_mode; f_check = i_check; wq.delete(); in_frame = 1; cs_defined = 1;
      end
      for (int k = 0; k < 4; k++)
        if (i_keep[k]) wq.push_back(i_data[k*16 +: 16]);
      if (i_last) begin
        frame_result();
        busy = 3;
        in_frame = 0;
      end
    end
    exp_ready = (busy == 0);
    exp_done  = (busy == 1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", 64'(o_ready), 64'(exp_ready));
      chk("done", 64'(o_done), 64'(exp_done));
      if (cs_defined) chk("checksum", 64'(o_checksum), 64'(e_cs));
      chk("ok", 64'(o_ok), 64'(e_ok));
      chk("err", 64'(o_err), 64'(e_err));
      chk("count", 64'(o_count), 64'(e_cnt));
    end
  end

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic l,
                           input logic m, input logic c);
    bit taken = 0;
    bit rdy;
    i_data = d; i_keep = k; i_last = l; i_mode = m; i_check = c; i_valid = 1'b1;
    for (int t = 0; t < 10 && !taken; t++) begin
      @(negedge clk);
      rdy = exp_ready;
      @(posedge clk);
      #1;
      taken = rdy;
    end
    if (!taken) chk("beat_accept_timeout", 64'd0, 64'd1);
    i_valid = 1'b0;
  endtask

  task automatic frame_check(input string nm, input logic [15:0] cs, input logic ok,
                             input logic [15:0] cnt);
    int lat = 99;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (o_done) begin lat = t; break; end
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk({nm, "_cs"}, 64'(o_checksum), 64'(cs));
    chk({nm, "_ok"}, 64'(o_ok), 64'(ok));
    chk({nm, "_cnt"}, 64'(o_count), 64'(cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic send_small(input logic [3:0] k, input logic l);
    s_data = {4{16'h1111}}; s_keep = k; s_last = l; s_mode = 1'b0; s_check = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    chk("small_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic small_check(input string nm, input logic ok, input logic err, input logic [3:0] cnt);
    bit seen = 0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge clk);
      seen = s_done;
    end
    chk({nm, "_done"}, 64'(seen), 64'd1);
    chk({nm, "_ok"}, 64'(s_ok), 64'(ok));
    chk({nm, "_err"}, 64'(s_err), 64'(err));
    chk({nm, "_cnt"}, 64'(s_cnt), 64'(cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_data = '0; i_keep = '0; i_valid = 1'b0; i_last = 1'b0;
    i_mode = 1'b0; i_check = 1'b0;
    s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; s_mode = 1'b0; s_check = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1;
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_cs", 64'(o_checksum), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    send_beat(pk(16'h0001, 16'hFFFF, 16'hAAAA, 16'hBBBB), 4'b0011, 1, 0, 0);
    frame_check("ones_gen_carry", 16'hFFFE, 0, 16'd2);
    send_beat(pk(16'h0001, 16'hFFFF, 16'h0, 16'h0), 4'b0011, 1, 1, 0);
    frame_check("twos_gen_wrap", 16'h0000, 0, 16'd2);
    send_beat(pk(16'h1234, 16'h5678, 16'h0, 16'h0), 4'b0011, 1, 1, 0);
    frame_check("twos_gen", 16'h9754, 0, 16'd2);
    send_beat(pk(16'h1234, 16'h5678, 16'h0, 16'h0), 4'b0011, 1, 0, 0);
    frame_check("ones_gen", 16'h9753, 0, 16'd2);

    // mode flip on the second beat must be ignored
    send_beat(pk(16'h1234, 16'h5678, 16'h9753, 16'hDEAD), 4'b0111, 0, 0, 1);
    send_beat(pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'b0000, 1, 1, 0);
    frame_check("ones_verify", 16'h0000, 1, 16'd3);
    send_beat(pk(16'h1235, 16'h5678, 16'h9753, 16'h0), 4'b0111, 1, 0, 1);
    frame_check("ones_verify_bad", 16'hFFFE, 0, 16'd3);
    send_beat(pk(16'h1234, 16'h5678, 16'h9754, 16'h0), 4'b0111, 1, 1, 1);
    frame_check("twos_verify", 16'h0000, 1, 16'd3);
    send_beat(pk(16'h1234, 16'h5678, 16'h9754, 16'h0), 4'b0000, 1, 0, 0);
    frame_check("empty_frame", 16'hFFFF, 0, 16'd0);

    send_beat(pk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 4'b1111, 0, 1, 0);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    chk("abort_cs", 64'(o_checksum), 64'd0);
    send_beat(pk(16'hFFFF, 16'h0, 16'h0, 16'h0), 4'b0001, 1, 0, 0);
    frame_check("after_abort", 16'h0000, 0, 16'd1);

    for (int b = 0; b < 100; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        i_data = {$urandom(), $urandom()};
        @(posedge clk);
        #1;
      end
      send_beat({$urandom(), $urandom()}, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if (in_frame) send_beat('0, 4'b0000, 1, 0, 0);
    repeat (5) @(posedge clk);
    #1;

    send_small(4'b1111, 0); send_small(4'b1111, 0); send_small(4'b1111, 0); send_small(4'b0111, 1);
    small_check("len15", 1, 0, 4'd15);
    send_small(4'b1111, 0); send_small(4'b1111, 0); send_small(4'b1111, 0); send_small(4'b1111, 1);
    small_check("len16_ovf", 0, 1, 4'd15);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
